// File: rtl/btb_pkg.sv
// Shared constants, default parameters and the entry layout for the branch target buffer.
package btb_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam int BTB_ENTRIES = 256;
    localparam int BTB_TAG_W   = 10;
    localparam int BTB_CNT_W   = 2;
    localparam int BTB_STAT_W  = 16;

    typedef struct packed {
        logic                 valid;
        logic [BTB_TAG_W-1:0] tag;
        logic [31:0]          target;
        logic                 jal;
        logic [BTB_CNT_W-1:0] cnt;
    } btb_entry_t;

endpackage

// File: rtl/btb_sat_cnt.sv
// Saturating event counter with synchronous clear.
// One-cycle update latency; holds at all-ones, no backpressure.
module btb_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != '1)) begin
            cnt_o <= cnt_o + 1'b1;
        end
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with per-entry saturating direction counter and lookup/mispredict stats.
// Lookup and mispredict are combinational, table writes land at the next edge; no backpressure.
module branch_target_buffer
    import btb_pkg::*;
#(
    parameter int ENTRIES = BTB_ENTRIES,
    parameter int TAG_W   = BTB_TAG_W,
    parameter int CNT_W   = BTB_CNT_W,
    parameter int STAT_W  = BTB_STAT_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              lookup_valid_i,
    input  logic [31:0]       lookup_pc_i,
    output logic              pred_hit_o,
    output logic              pred_taken_o,
    output logic [31:0]       pred_target_o,
    input  logic              upd_valid_i,
    input  logic [31:0]       upd_pc_i,
    input  logic              upd_is_br_i,
    input  logic              upd_is_jal_i,
    input  logic              upd_taken_i,
    input  logic [31:0]       upd_target_i,
    input  logic              upd_pred_taken_i,
    input  logic [31:0]       upd_pred_target_i,
    output logic              mispredict_o,
    output logic [31:0]       redirect_pc_o,
    input  logic              flush_i,
    output logic [STAT_W-1:0] stat_lookups_o,
    output logic [STAT_W-1:0] stat_hits_o,
    output logic [STAT_W-1:0] stat_mispred_o
);

    localparam int               IDX_W    = $clog2(ENTRIES);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1 << (CNT_W - 1));

    // Valid bits live outside the array so only they need a reset.
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        logic             jal;
        logic [CNT_W-1:0] cnt;
    } entry_t;

    entry_t             mem [ENTRIES];
    logic [ENTRIES-1:0] valid_q;

    logic [IDX_W-1:0] l_idx, u_idx;
    logic [TAG_W-1:0] l_tag, u_tag;
    entry_t           l_ent, u_ent, wr_ent;
    logic             u_hit, upd_ctl, wr_en;

    assign l_idx = lookup_pc_i[IDX_W+1:2];
    assign l_tag = lookup_pc_i[IDX_W+TAG_W+1:IDX_W+2];
    assign u_idx = upd_pc_i[IDX_W+1:2];
    assign u_tag = upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];
    assign l_ent = mem[l_idx];
    assign u_ent = mem[u_idx];

    assign pred_hit_o    = valid_q[l_idx] && (l_ent.tag == l_tag);
    assign pred_taken_o  = pred_hit_o && (l_ent.jal || l_ent.cnt[CNT_W-1]);
    assign pred_target_o = pred_taken_o ? l_ent.target : lookup_pc_i + 32'd4;

    assign u_hit   = valid_q[u_idx] && (u_ent.tag == u_tag);
    assign upd_ctl = upd_valid_i && (upd_is_br_i || upd_is_jal_i);
    // A not-taken miss leaves the table alone; flush and reset suppress writes.
    assign wr_en   = rst_ni && !flush_i && upd_ctl && (u_hit || upd_taken_i);

    always_comb begin
        wr_ent = u_ent;
        if (u_hit) begin
            if (upd_taken_i) begin
                wr_ent.target = upd_target_i;
                if (u_ent.cnt != CNT_MAX) wr_ent.cnt = u_ent.cnt + 1'b1;
            end else if (u_ent.cnt != '0) begin
                wr_ent.cnt = u_ent.cnt - 1'b1;
            end
        end else begin
            wr_ent.tag    = u_tag;
            wr_ent.target = upd_target_i;
            wr_ent.jal    = upd_is_jal_i;
            wr_ent.cnt    = CNT_WEAK;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[u_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[u_idx] <= wr_ent;
        end
    end

    assign mispredict_o  = upd_valid_i &&
                           ((upd_pred_taken_i != upd_taken_i) ||
                            (upd_taken_i && upd_pred_taken_i && (upd_pred_target_i != upd_target_i)));
    assign redirect_pc_o = upd_taken_i ? upd_target_i : upd_pc_i + 32'd4;

    btb_sat_cnt #(.W(STAT_W)) u_stat_lookups (
        .clk_i (clk_i),
        .clr_i (!rst_ni),
        .inc_i (lookup_valid_i),
        .cnt_o (stat_lookups_o)
    );

    btb_sat_cnt #(.W(STAT_W)) u_stat_hits (
        .clk_i (clk_i),
        .clr_i (!rst_ni),
        .inc_i (lookup_valid_i && pred_hit_o),
        .cnt_o (stat_hits_o)
    );

    btb_sat_cnt #(.W(STAT_W)) u_stat_mispred (
        .clk_i (clk_i),
        .clr_i (!rst_ni),
        .inc_i (mispredict_o),
        .cnt_o (stat_mispred_o)
    );

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: directed vectors push expectations, a negedge monitor checks.
module tb_branch_target_buffer;

    localparam int ENTRIES = 256;
    localparam int TAG_W   = 10;
    localparam int CNT_W   = 2;
    localparam int STAT_W  = 4;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              lookup_valid_i;
    logic [31:0]       lookup_pc_i;
    logic              pred_hit_o, pred_taken_o;
    logic [31:0]       pred_target_o;
    logic              upd_valid_i, upd_is_br_i, upd_is_jal_i, upd_taken_i, upd_pred_taken_i;
    logic [31:0]       upd_pc_i, upd_target_i, upd_pred_target_i;
    logic              mispredict_o;
    logic [31:0]       redirect_pc_o;
    logic              flush_i;
    logic [STAT_W-1:0] stat_lookups_o, stat_hits_o, stat_mispred_o;

    always #5 clk_i = ~clk_i;

    branch_target_buffer #(
        .ENTRIES(ENTRIES), .TAG_W(TAG_W), .CNT_W(CNT_W), .STAT_W(STAT_W)
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .lookup_valid_i    (lookup_valid_i),
        .lookup_pc_i       (lookup_pc_i),
        .pred_hit_o        (pred_hit_o),
        .pred_taken_o      (pred_taken_o),
        .pred_target_o     (pred_target_o),
        .upd_valid_i       (upd_valid_i),
        .upd_pc_i          (upd_pc_i),
        .upd_is_br_i       (upd_is_br_i),
        .upd_is_jal_i      (upd_is_jal_i),
        .upd_taken_i       (upd_taken_i),
        .upd_target_i      (upd_target_i),
        .upd_pred_taken_i  (upd_pred_taken_i),
        .upd_pred_target_i (upd_pred_target_i),
        .mispredict_o      (mispredict_o),
        .redirect_pc_o     (redirect_pc_o),
        .flush_i           (flush_i),
        .stat_lookups_o    (stat_lookups_o),
        .stat_hits_o       (stat_hits_o),
        .stat_mispred_o    (stat_mispred_o)
    );

    typedef struct packed { logic hit; logic taken; logic [31:0] tgt; } lk_exp_t;
    typedef struct packed { logic mp; logic [31:0] redir; } up_exp_t;
    typedef struct packed { logic [STAT_W-1:0] lk; logic [STAT_W-1:0] hit; logic [STAT_W-1:0] mp; } st_exp_t;

    lk_exp_t lq[$];
    up_exp_t uq[$];
    st_exp_t sq[$];

    int n_cmp = 0;
    int n_bad = 0;
    logic stat_chk = 1'b0;
    logic cur_hit = 1'b0;
    logic cur_mp = 1'b0;
    logic [STAT_W-1:0] m_lk = '0, m_hit = '0, m_mp = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic missing(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: output presented with no expected entry at %0t", name, $time);
    endtask

    function automatic logic [STAT_W-1:0] sat(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // Monitor: compares whatever the DUT presents against the queued expectations.
    initial begin : monitor
        lk_exp_t le;
        up_exp_t ue;
        st_exp_t se;
        forever begin
            @(negedge clk_i);
            if (lookup_valid_i) begin
                if (lq.size() == 0) missing("lookup");
                else begin
                    le = lq.pop_front();
                    chk("pred_hit", {31'd0, pred_hit_o}, {31'd0, le.hit});
                    chk("pred_taken", {31'd0, pred_taken_o}, {31'd0, le.taken});
                    chk("pred_target", pred_target_o, le.tgt);
                end
            end
            if (upd_valid_i) begin
                if (uq.size() == 0) missing("update");
                else begin
                    ue = uq.pop_front();
                    chk("mispredict", {31'd0, mispredict_o}, {31'd0, ue.mp});
                    chk("redirect_pc", redirect_pc_o, ue.redir);
                end
            end else begin
                chk("mispredict_idle", {31'd0, mispredict_o}, 32'd0);
            end
            if (stat_chk) begin
                if (sq.size() == 0) missing("stats");
                else begin
                    se = sq.pop_front();
                    chk("stat_lookups", {28'd0, stat_lookups_o}, {28'd0, se.lk});
                    chk("stat_hits", {28'd0, stat_hits_o}, {28'd0, se.hit});
                    chk("stat_mispred", {28'd0, stat_mispred_o}, {28'd0, se.mp});
                end
            end
        end
    end

    task automatic idle();
        rst_ni            = 1'b1;
        lookup_valid_i    = 1'b0;
        lookup_pc_i       = '0;
        upd_valid_i       = 1'b0;
        upd_pc_i          = '0;
        upd_is_br_i       = 1'b0;
        upd_is_jal_i      = 1'b0;
        upd_taken_i       = 1'b0;
        upd_target_i      = '0;
        upd_pred_taken_i  = 1'b0;
        upd_pred_target_i = '0;
        flush_i           = 1'b0;
        stat_chk          = 1'b0;
        cur_hit           = 1'b0;
        cur_mp            = 1'b0;
    endtask

    task automatic set_lk(input logic [31:0] pc, input logic h, input logic t, input logic [31:0] tg);
        lookup_valid_i = 1'b1;
        lookup_pc_i    = pc;
        cur_hit        = h;
        lq.push_back('{hit: h, taken: t, tgt: tg});
    endtask

    task automatic set_up(input logic [31:0] pc, input logic br, input logic jal, input logic tk,
                          input logic [31:0] tg, input logic ptk, input logic [31:0] ptg,
                          input logic mp, input logic [31:0] rd);
        upd_valid_i       = 1'b1;
        upd_pc_i          = pc;
        upd_is_br_i       = br;
        upd_is_jal_i      = jal;
        upd_taken_i       = tk;
        upd_target_i      = tg;
        upd_pred_taken_i  = ptk;
        upd_pred_target_i = ptg;
        cur_mp            = mp;
        uq.push_back('{mp: mp, redir: rd});
    endtask

    // Queue the pre-edge statistics, advance the stats model, then clock one edge.
    task automatic step();
        sq.push_back('{lk: m_lk, hit: m_hit, mp: m_mp});
        stat_chk = 1'b1;
        if (!rst_ni) begin
            m_lk = '0; m_hit = '0; m_mp = '0;
        end else begin
            if (lookup_valid_i) begin
                m_lk = sat(m_lk);
                if (cur_hit) m_hit = sat(m_hit);
            end
            if (upd_valid_i && cur_mp) m_mp = sat(m_mp);
        end
        @(posedge clk_i);
        #1;
        idle();
    endtask

    initial begin : stimulus
        idle();
        rst_ni = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b0; step();

        // Out of reset: miss, fall-through target, stats zero.
        set_lk(32'h0000_1000, 0, 0, 32'h0000_1004); step();

        // Taken branch allocates weakly-taken entry.
        set_up(32'h100, 1, 0, 1, 32'h200, 0, 32'h104, 1, 32'h200); step();
        set_lk(32'h100, 1, 1, 32'h200); step();

        // Not-taken twice; first cycle's lookup sees pre-write contents.
        set_lk(32'h100, 1, 1, 32'h200);
        set_up(32'h100, 1, 0, 0, 32'h200, 1, 32'h200, 1, 32'h104); step();
        set_up(32'h100, 1, 0, 0, 32'h200, 0, 32'h104, 0, 32'h104); step();
        set_lk(32'h100, 1, 0, 32'h104); step();

        // Four taken saturate at 3; one not-taken still predicts taken.
        for (int i = 0; i < 4; i++) begin
            set_up(32'h100, 1, 0, 1, 32'h200, 1, 32'h200, 0, 32'h200); step();
        end
        set_lk(32'h100, 1, 1, 32'h200); step();
        set_up(32'h100, 1, 0, 0, 32'h200, 1, 32'h200, 1, 32'h104); step();
        set_lk(32'h100, 1, 1, 32'h200); step();

        // JALR-class update must not touch the table.
        set_up(32'h100, 0, 0, 1, 32'h9999_0000, 1, 32'h200, 1, 32'h9999_0000); step();
        set_lk(32'h100, 1, 1, 32'h200); step();

        // Alias 0x100 + 4*ENTRIES: tag mismatch, then JAL replaces entry.
        set_lk(32'h500, 0, 0, 32'h504); step();
        set_up(32'h500, 0, 1, 1, 32'h800, 0, 32'h504, 1, 32'h800); step();
        set_lk(32'h500, 1, 1, 32'h800); step();
        set_lk(32'h100, 0, 0, 32'h104); step();
        // Counter drops below taken threshold; jal flag keeps it taken.
        set_up(32'h500, 1, 0, 0, 32'h800, 1, 32'h800, 1, 32'h504); step();
        set_lk(32'h500, 1, 1, 32'h800); step();

        // Flush wins over same-cycle allocation at 0x300.
        flush_i = 1'b1;
        set_up(32'h300, 1, 0, 1, 32'h400, 0, 32'h304, 1, 32'h400); step();
        set_lk(32'h500, 0, 0, 32'h504); step();
        set_lk(32'h300, 0, 0, 32'h304); step();

        // Push lookups past 2^STAT_W-1.
        for (int i = 0; i < 10; i++) begin
            set_lk(32'h0000_1000, 0, 0, 32'h0000_1004); step();
        end
        set_up(32'h100, 1, 0, 1, 32'h200, 0, 32'h104, 1, 32'h200); step();
        set_lk(32'h100, 1, 1, 32'h200); step();

        // Reset mid-sequence overrides a same-cycle allocation.
        rst_ni = 1'b0;
        set_lk(32'h100, 1, 1, 32'h200);
        set_up(32'h700, 1, 0, 1, 32'h7a0, 0, 32'h704, 1, 32'h7a0); step();
        set_lk(32'h100, 0, 0, 32'h104); step();
        set_lk(32'h700, 0, 0, 32'h704); step();
        step();

        @(posedge clk_i);
        @(posedge clk_i);
        n_cmp++;
        if ((lq.size() + uq.size() + sq.size()) != 0) begin
            n_bad++;
            $display("FAIL queue_drain: got %0d pending expected 0", lq.size() + uq.size() + sq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
